keynsham_tcm: RTL and testbench



---
 rtl/keynsham_tcm_pkg.sv | 23 ++
 rtl/keynsham_ack_pipe.sv | 50 +++++
 rtl/keynsham_tcm.sv | 91 +++++++++
 tb/tb_keynsham_tcm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keynsham_tcm_pkg.sv
// Shared constants and helpers for the Keynsham tightly-coupled memory.
// Imported by the TCM top and its ack pipeline.
package keynsham_tcm_pkg;

    localparam int word_bits        = 32;
    localparam int byte_lanes       = 4;
    localparam int max_read_latency = 4;

    function automatic int index_bits(input int words);
        return $clog2(words);
    endfunction

    // Window decode on word addresses; the limit is formed in 33 bits so a
    // window ending exactly at the top of the 4 GiB space does not wrap.
    function automatic logic cs_gen(input logic [29:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
        logic [32:0] limit;
        limit = {1'b0, base} + {1'b0, size};
        return (addr >= base[31:2]) && ({1'b0, addr} < limit[32:2]);
    endfunction

endpackage

// File: rtl/keynsham_ack_pipe.sv
// Fixed-depth delay line carrying {valid, error, data} from acceptance to ack.
// Only the valid bits are reset, so in-flight accesses vanish on reset.
module keynsham_ack_pipe
    import keynsham_tcm_pkg::*;
#(
    parameter int latency = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_error,
    input  logic [word_bits-1:0] in_data,
    output logic                 ack,
    output logic                 error,
    output logic [word_bits-1:0] data
);

    logic [latency-1:0]   valid_q;
    logic                 error_q [latency];
    logic [word_bits-1:0] data_q  [latency];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value, whatever the loop order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int s = 1; s < latency; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only observed through
    // a valid bit, and leaving them unreset keeps them plain flops.
    always_ff @(posedge clk) begin
        error_q[0] <= in_error;
        data_q[0]  <= in_data;
        for (int s = 1; s < latency; s++) begin
            error_q[s] <= error_q[s-1];
            data_q[s]  <= data_q[s-1];
        end
    end

    assign ack   = valid_q[latency-1];
    assign error = valid_q[latency-1] && error_q[latency-1];
    assign data  = valid_q[latency-1] ? data_q[latency-1] : '0;

endmodule

// File: rtl/keynsham_tcm.sv
// Dual-port TCM: read-only instruction port, byte-writable data port, each
// decoding its own window and returning acks after a fixed read latency.
module keynsham_tcm
    import keynsham_tcm_pkg::*;
#(
    parameter logic [31:0] bus_address  = 32'h0,
    parameter logic [31:0] bus_size     = 32'h2000,
    parameter int          words        = 2048,
    parameter int          read_latency = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_access,
    output logic                  i_cs,
    input  logic [29:0]           i_addr,
    output logic [word_bits-1:0]  i_data,
    output logic                  i_ack,
    input  logic                  d_access,
    output logic                  d_cs,
    input  logic [29:0]           d_addr,
    input  logic [byte_lanes-1:0] d_bytesel,
    input  logic [word_bits-1:0]  d_wr_val,
    input  logic                  d_wr_en,
    output logic [word_bits-1:0]  d_data,
    output logic                  d_ack,
    output logic                  d_error
);

    localparam int          ib        = index_bits(words);
    localparam logic [29:0] base_word = bus_address[31:2];
    localparam logic [30:0] words_lim = 31'(words);

    logic [word_bits-1:0] mem [words];

    logic [29:0]          i_index, d_index;
    logic                 i_in_range, d_in_range;
    logic                 i_accept, d_accept;
    logic [word_bits-1:0] i_rd, d_rd;
    logic                 i_err;
    logic [word_bits-1:0] i_pipe_data;

    assign i_cs       = cs_gen(i_addr, bus_address, bus_size);
    assign d_cs       = cs_gen(d_addr, bus_address, bus_size);
    assign i_index    = i_addr - base_word;
    assign d_index    = d_addr - base_word;
    assign i_in_range = {1'b0, i_index} < words_lim;
    assign d_in_range = {1'b0, d_index} < words_lim;
    assign i_accept   = i_access && i_cs;
    assign d_accept   = d_access && d_cs;

    // Contents survive reset by design, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (d_accept && d_wr_en && d_in_range) begin
            for (int b = 0; b < byte_lanes; b++) begin
                if (d_bytesel[b]) begin
                    mem[d_index[ib-1:0]][8*b +: 8] <= d_wr_val[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the pre-edge array, so an I read colliding with a D write
    // returns the old word.
    assign i_rd = mem[i_index[ib-1:0]];
    assign d_rd = (!d_wr_en && d_in_range) ? mem[d_index[ib-1:0]] : '0;

    keynsham_ack_pipe #(.latency(read_latency)) u_i_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (i_accept),
        .in_error (!i_in_range),
        .in_data  (i_rd),
        .ack      (i_ack),
        .error    (i_err),
        .data     (i_pipe_data)
    );

    assign i_data = i_err ? '0 : i_pipe_data;

    keynsham_ack_pipe #(.latency(read_latency)) u_d_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (d_accept),
        .in_error (!d_in_range),
        .in_data  (d_rd),
        .ack      (d_ack),
        .error    (d_error),
        .data     (d_data)
    );

endmodule

// File: tb/tb_keynsham_tcm.sv
// Directed bench for keynsham_tcm: three instances with latencies 1, 3 and 4
// share one clock and reset; inputs change and outputs are sampled on negedge.
module tb_keynsham_tcm;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_access  [3];
    logic        i_cs      [3];
    logic [29:0] i_addr    [3];
    logic [31:0] i_data    [3];
    logic        i_ack     [3];
    logic        d_access  [3];
    logic        d_cs      [3];
    logic [29:0] d_addr    [3];
    logic [3:0]  d_bytesel [3];
    logic [31:0] d_wr_val  [3];
    logic        d_wr_en   [3];
    logic [31:0] d_data    [3];
    logic        d_ack     [3];
    logic        d_error   [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    keynsham_tcm #(.bus_address(32'h2000_0000), .bus_size(32'h4000),
                   .words(2048), .read_latency(1)) u0 (
        .clk(clk), .rst(rst),
        .i_access(i_access[0]), .i_cs(i_cs[0]), .i_addr(i_addr[0]),
        .i_data(i_data[0]), .i_ack(i_ack[0]),
        .d_access(d_access[0]), .d_cs(d_cs[0]), .d_addr(d_addr[0]),
        .d_bytesel(d_bytesel[0]), .d_wr_val(d_wr_val[0]), .d_wr_en(d_wr_en[0]),
        .d_data(d_data[0]), .d_ack(d_ack[0]), .d_error(d_error[0]));

    keynsham_tcm #(.bus_address(32'h0), .bus_size(32'h2000),
                   .words(2048), .read_latency(3)) u1 (
        .clk(clk), .rst(rst),
        .i_access(i_access[1]), .i_cs(i_cs[1]), .i_addr(i_addr[1]),
        .i_data(i_data[1]), .i_ack(i_ack[1]),
        .d_access(d_access[1]), .d_cs(d_cs[1]), .d_addr(d_addr[1]),
        .d_bytesel(d_bytesel[1]), .d_wr_val(d_wr_val[1]), .d_wr_en(d_wr_en[1]),
        .d_data(d_data[1]), .d_ack(d_ack[1]), .d_error(d_error[1]));

    keynsham_tcm #(.bus_address(32'h0), .bus_size(32'h2000),
                   .words(2048), .read_latency(4)) u2 (
        .clk(clk), .rst(rst),
        .i_access(i_access[2]), .i_cs(i_cs[2]), .i_addr(i_addr[2]),
        .i_data(i_data[2]), .i_ack(i_ack[2]),
        .d_access(d_access[2]), .d_cs(d_cs[2]), .d_addr(d_addr[2]),
        .d_bytesel(d_bytesel[2]), .d_wr_val(d_wr_val[2]), .d_wr_en(d_wr_en[2]),
        .d_data(d_data[2]), .d_ack(d_ack[2]), .d_error(d_error[2]));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic int lat(input int u);
        case (u)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    // Issue one D access at the current negedge and check its ack exactly
    // lat(u) cycles later, with no early ack.
    task automatic d_xfer(input int u, input bit wr, input logic [29:0] a,
                          input logic [3:0] be, input logic [31:0] v,
                          input logic [31:0] exp_data, input bit exp_err,
                          input string tag);
        d_access[u] = 1'b1; d_wr_en[u] = wr; d_addr[u] = a;
        d_bytesel[u] = be;  d_wr_val[u] = v;
        @(negedge clk);
        d_access[u] = 1'b0;
        repeat (lat(u) - 1) begin
            check({tag, "_early"}, 32'(d_ack[u]), 32'd0);
            @(negedge clk);
        end
        check({tag, "_ack"},  32'(d_ack[u]),   32'd1);
        check({tag, "_data"}, d_data[u],       exp_data);
        check({tag, "_err"},  32'(d_error[u]), 32'(exp_err));
    endtask

    task automatic i_read(input int u, input logic [29:0] a,
                          input logic [31:0] exp_data, input string tag);
        i_access[u] = 1'b1; i_addr[u] = a;
        @(negedge clk);
        i_access[u] = 1'b0;
        repeat (lat(u) - 1) @(negedge clk);
        check({tag, "_ack"},  32'(i_ack[u]), 32'd1);
        check({tag, "_data"}, i_data[u],     exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit saw_ack;
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            i_access[u] = 1'b0; i_addr[u] = '0;
            d_access[u] = 1'b0; d_addr[u] = '0; d_bytesel[u] = '0;
            d_wr_val[u] = '0;   d_wr_en[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_i_ack%0d", u),   32'(i_ack[u]),   32'd0);
            check($sformatf("rst_d_ack%0d", u),   32'(d_ack[u]),   32'd0);
            check($sformatf("rst_d_error%0d", u), 32'(d_error[u]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Latency 1, window at 0x2000_0000
        d_xfer(0, 1'b1, 30'h0800_0010, 4'b1111, 32'hdeadbeef, 32'h0, 1'b0, "wr_full");
        d_xfer(0, 1'b0, 30'h0800_0010, 4'b1111, 32'h0, 32'hdeadbeef, 1'b0, "rd_full");
        @(negedge clk);
        check("no_extra_ack", 32'(d_ack[0]), 32'd0);

        d_xfer(0, 1'b1, 30'h0800_0011, 4'b1111, 32'h11223344, 32'h0, 1'b0, "be_init");
        d_xfer(0, 1'b1, 30'h0800_0011, 4'b0101, 32'haabbccdd, 32'h0, 1'b0, "be_wr");
        d_xfer(0, 1'b0, 30'h0800_0011, 4'b1111, 32'h0, 32'h11bb33dd, 1'b0, "be_rd");
        d_xfer(0, 1'b1, 30'h0800_0011, 4'b0000, 32'hffffffff, 32'h0, 1'b0, "be0_wr");
        d_xfer(0, 1'b0, 30'h0800_0011, 4'b1111, 32'h0, 32'h11bb33dd, 1'b0, "be0_rd");

        // Out-of-range: index 2048 lies inside the 16 KiB window
        d_xfer(0, 1'b1, 30'h0800_0000, 4'b1111, 32'hcafef00d, 32'h0, 1'b0, "w_idx0");
        d_xfer(0, 1'b1, 30'h0800_0800, 4'b1111, 32'h12345678, 32'h0, 1'b1, "w_oor");
        d_xfer(0, 1'b0, 30'h0800_0800, 4'b1111, 32'h0, 32'h0, 1'b1, "r_oor");
        d_xfer(0, 1'b0, 30'h0800_0000, 4'b1111, 32'h0, 32'hcafef00d, 1'b0, "r_idx0");
        i_read(0, 30'h0800_0900, 32'h0, "i_oor");

        // Window edges and an access outside the window
        d_addr[0] = 30'h07ff_ffff; i_addr[0] = 30'h0800_0000;
        #1;
        check("cs_below", 32'(d_cs[0]), 32'd0);
        check("cs_base",  32'(i_cs[0]), 32'd1);
        d_addr[0] = 30'h0800_0fff;
        #1;
        check("cs_last", 32'(d_cs[0]), 32'd1);
        d_access[0] = 1'b1; d_wr_en[0] = 1'b0; d_addr[0] = 30'h0800_1000;
        #1;
        check("cs_above", 32'(d_cs[0]), 32'd0);
        @(negedge clk);
        d_access[0] = 1'b0;
        check("outside_no_ack", 32'(d_ack[0]), 32'd0);

        // Latency 3: preload, then a back-to-back I burst
        for (int k = 0; k < 4; k++) begin
            d_xfer(1, 1'b1, 30'(32'h100 + k), 4'b1111, 32'ha000_0000 + 32'(k),
                   32'h0, 1'b0, $sformatf("pre%0d", k));
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                i_access[1] = 1'b1; i_addr[1] = 30'(32'h100 + c);
            end else begin
                i_access[1] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("burst_ack%0d", c), 32'(i_ack[1]),
                  32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5)
                check($sformatf("burst_data%0d", c), i_data[1],
                      32'ha000_0000 + 32'(c - 2));
            else
                check($sformatf("burst_idle%0d", c), i_data[1], 32'h0);
        end

        // Same-cycle I read and D write to one word
        d_xfer(1, 1'b1, 30'h200, 4'b1111, 32'h1, 32'h0, 1'b0, "coll_init");
        i_access[1] = 1'b1; i_addr[1] = 30'h200;
        d_access[1] = 1'b1; d_wr_en[1] = 1'b1; d_addr[1] = 30'h200;
        d_bytesel[1] = 4'b1111; d_wr_val[1] = 32'h2;
        @(negedge clk);
        i_access[1] = 1'b0; d_access[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("coll_i_ack",  32'(i_ack[1]), 32'd1);
        check("coll_i_data", i_data[1],     32'h1);
        check("coll_d_ack",  32'(d_ack[1]), 32'd1);
        i_read(1, 30'h200, 32'h2, "coll_after");

        // Latency 4: reset while two reads are in flight
        d_xfer(2, 1'b1, 30'h40, 4'b1111, 32'h55aa55aa, 32'h0, 1'b0, "rst_pre");
        d_access[2] = 1'b1; d_wr_en[2] = 1'b0; d_addr[2] = 30'h40;
        @(negedge clk);
        d_addr[2] = 30'h41;
        @(negedge clk);
        d_access[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (d_ack[2]) saw_ack = 1'b1;
        end
        check("rst_no_late_ack", 32'(saw_ack), 32'd0);
        d_xfer(2, 1'b0, 30'h40, 4'b1111, 32'h0, 32'h55aa55aa, 1'b0, "rst_keep");
        d_xfer(0, 1'b0, 30'h0800_0011, 4'b1111, 32'h0, 32'h11bb33dd, 1'b0, "rst_keep0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
